// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive-side buffer.
//   UART_DATA_W : width of one received character.
//   rx_state_e  : unload FSM states (IDLE -> UNLOAD -> CAPTURE -> IDLE).
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      UNLOAD  = 2'd1,
      CAPTURE = 2'd2
   } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: DEPTH x UART_DATA_W synchronous FIFO with a first-word-fall-through
// read side, all state in the rxclk domain.
//   rxclk, reset : clock, asynchronous active-high reset
//   flush        : synchronous clear, wins over write and pop
//   wr_en/wr_data: write one entry at the write pointer
//   rd_ready     : pop the head entry when rd_valid is also high
//   rd_data      : head entry (don't-care while rd_valid is low)
//   rd_valid     : FIFO non-empty
//   level        : occupancy 0..DEPTH
//   full         : level == DEPTH
// The caller must not write while full unless a pop happens in the same cycle.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                   rxclk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   rd_ready,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   output logic [AW:0]            level,
   output logic                   full
);

   logic [UART_DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [AW:0]            level_q, level_d;
   logic                   do_wr, do_pop;

   assign rd_valid = (level_q != '0);
   assign full     = (level_q == (AW+1)'(DEPTH));
   assign level    = level_q;
   assign rd_data  = mem[rd_ptr_q];

   assign do_wr  = wr_en & ~flush;
   assign do_pop = rd_ready & rd_valid & ~flush;

   always_comb begin
      level_d = level_q;
      if (flush) begin
         level_d = '0;
      end else if (do_wr && !do_pop) begin
         level_d = level_q + (AW+1)'(1);
      end else if (!do_wr && do_pop) begin
         level_d = level_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         level_q <= level_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            // Pointers are exactly AW bits, so increment wraps modulo DEPTH.
            if (do_wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Storage is not reset; rd_data is only meaningful while rd_valid is high.
   always_ff @(posedge rxclk) begin
      if (do_wr) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver. Watches rx_empty_i, pulses
// uld_rx_data_o for one cycle to unload a byte, captures rx_data_i the next cycle into a
// DEPTH-entry FIFO, and presents it through a first-word-fall-through valid/ready port.
//   reset, rxclk   : asynchronous active-high reset, receive clock
//   en             : allow new unloads to start
//   flush          : synchronous clear of FIFO contents and FSM
//   rx_empty_i     : receiver holding register empty (0 = byte waiting)
//   rx_data_i      : receiver byte, valid the cycle after uld_rx_data_o
//   uld_rx_data_o  : registered one-cycle unload pulse
//   rd_data/rd_valid/rd_ready : host read port
//   level, full    : FIFO occupancy and full flag
// Build option UART_RX_FIFO_DROP_EN: keep unloading while full, discard the byte and count
// it on drop_cnt (saturating at 255) instead of back-pressuring the receiver.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                   reset,
   input  logic                   rxclk,
   input  logic                   en,
   input  logic                   flush,
   input  logic                   rx_empty_i,
   input  logic [UART_DATA_W-1:0] rx_data_i,
   output logic                   uld_rx_data_o,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [AW:0]            level,
   output logic                   full
`ifdef UART_RX_FIFO_DROP_EN
   ,
   output logic [7:0]             drop_cnt
`endif
);

   rx_state_e state_q, state_d;
   logic      uld_q;
   logic      capture;
   logic      wr_en;
   logic      room;
   logic      fifo_full;

   assign capture = (state_q == CAPTURE);

`ifdef UART_RX_FIFO_DROP_EN
   logic [7:0] drop_cnt_q;

   assign room     = 1'b1;
   assign wr_en    = capture & ~fifo_full;
   assign drop_cnt = drop_cnt_q;

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else if (flush) begin
         drop_cnt_q <= '0;
      end else if (capture && fifo_full && drop_cnt_q != 8'hFF) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end
`else
   // Full is only checked in IDLE: between that check and CAPTURE the level can only fall.
   assign room  = ~fifo_full;
   assign wr_en = capture;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en && !rx_empty_i && room) state_d = UNLOAD;
         UNLOAD:  state_d = CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         uld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // Registered copy of "next state is UNLOAD": high exactly while in UNLOAD.
         uld_q   <= (state_d == UNLOAD);
      end
   end

   assign uld_rx_data_o = uld_q;
   assign full          = fifo_full;

   uart_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .rxclk    (rxclk),
      .reset    (reset),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_data  (rx_data_i),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .level    (level),
      .full     (fifo_full)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo. A small receiver model feeds bytes
// and honours unload pulses; a queue-based model of the buffer predicts contents and level.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;

   logic       reset, rxclk, en, flush, rx_empty_i, rd_ready;
   logic [7:0] rx_data_i, rd_data;
   logic       uld_rx_data_o, rd_valid, full;
   logic [4:0] level;
`ifdef UART_RX_FIFO_DROP_EN
   logic [7:0] drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] mq[$];
   logic [7:0] feed[$];
   bit         rx_hold;
   logic [7:0] rx_byte;
   int         gap;
   bit         prev_uld, prev_flush, uld_double;
   logic [7:0] unl_byte;
   int         n_uld;
   int         drop_m;

   uart_rx_fifo #(
      .DEPTH (DEPTH)
   ) dut (
      .reset         (reset),
      .rxclk         (rxclk),
      .en            (en),
      .flush         (flush),
      .rx_empty_i    (rx_empty_i),
      .rx_data_i     (rx_data_i),
      .uld_rx_data_o (uld_rx_data_o),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .level         (level),
      .full          (full)
`ifdef UART_RX_FIFO_DROP_EN
      ,
      .drop_cnt      (drop_cnt)
`endif
   );

   initial rxclk = 1'b0;
   always #5 rxclk = ~rxclk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic drive_rx();
      rx_empty_i = !rx_hold;
      rx_data_i  = rx_byte;
   endtask

   task automatic model_clear();
      mq.delete();
      prev_uld   = 0;
      prev_flush = 0;
      drop_m     = 0;
   endtask

   // One clock: update model from the inputs/outputs seen before the edge, then redrive.
   task automatic step();
      bit cu, cf, cr, cap;
      int sz;
      cu  = uld_rx_data_o;
      cf  = flush;
      cr  = rd_ready;
      cap = prev_uld && !prev_flush && !cf;
      sz  = mq.size();
      @(posedge rxclk);
      if (cu && prev_uld) uld_double = 1;
      if (cf) begin
         mq.delete();
         drop_m = 0;
      end else begin
         if (cr && sz > 0) void'(mq.pop_front());
         if (cap) begin
            if (sz < DEPTH) mq.push_back(unl_byte);
            else if (drop_m < 255) drop_m++;
         end
      end
      if (cu) begin
         n_uld++;
         unl_byte = rx_data_i;
         rx_hold  = 0;
         gap      = 1 + int'($urandom_range(0, 3));
      end else if (!rx_hold) begin
         if (gap > 0) gap--;
         else if (feed.size() > 0) begin
            rx_hold = 1;
            rx_byte = feed.pop_front();
         end
      end
      prev_uld   = cu;
      prev_flush = cf;
      #1;
      drive_rx();
   endtask

   task automatic run_until(input int n, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (mq.size() == n && feed.size() == 0 && !rx_hold && !prev_uld) begin
            ok = 1;
            break;
         end
         step();
      end
   endtask

   task automatic load_now(input logic [7:0] b);
      rx_hold = 1;
      rx_byte = b;
      gap     = 0;
      drive_rx();
   endtask

   task automatic test_reset();
      en = 0; flush = 0; rd_ready = 0;
      rx_hold = 0; rx_byte = 8'h00; gap = 0; n_uld = 0; uld_double = 0;
      drive_rx();
      reset = 1;
      model_clear();
      repeat (2) @(posedge rxclk);
      #1;
      checks++;
      if (uld_rx_data_o !== 1'b0) begin
         failures++; $display("FAIL reset_uld got=%0b exp=0", uld_rx_data_o);
      end
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid);
      end
      checks++;
      if (level !== 5'd0) begin
         failures++; $display("FAIL reset_level got=%0d exp=0", level);
      end
      checks++;
      if (full !== 1'b0) begin
         failures++; $display("FAIL reset_full got=%0b exp=0", full);
      end
`ifdef UART_RX_FIFO_DROP_EN
      checks++;
      if (drop_cnt !== 8'd0) begin
         failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt);
      end
`endif
      reset = 0;
      en    = 1;
   endtask

   task automatic test_single_byte();
      rd_ready = 0;
      load_now(8'hA5);
      step();
      checks++;
      if (uld_rx_data_o !== 1'b1) begin
         failures++; $display("FAIL single_uld_rise got=%0b exp=1", uld_rx_data_o);
      end
      step();
      checks++;
      if (uld_rx_data_o !== 1'b0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_capture_cycle uld=%0b rd_valid=%0b exp uld=0 rd_valid=0",
                  uld_rx_data_o, rd_valid);
      end
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== 5'd1) begin
         failures++;
         $display("FAIL single_visible valid=%0b data=%h level=%0d exp valid=1 data=a5 level=1",
                  rd_valid, rd_data, level);
      end
      rd_ready = 1;
      step();
      rd_ready = 0;
      checks++;
      if (rd_valid !== 1'b0 || level !== 5'd0) begin
         failures++;
         $display("FAIL single_pop valid=%0b level=%0d exp valid=0 level=0", rd_valid, level);
      end
   endtask

   task automatic test_fill();
      int n0;
      bit ok;
      rd_ready = 0;
      n0 = n_uld;
      for (int i = 0; i <= 16; i++) feed.push_back(8'(i));
      // Stop once 16 are stored; the 17th stays in the receiver.
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         if (mq.size() == 16) begin
            ok = 1;
            break;
         end
         step();
      end
      repeat (20) step();
      checks++;
      if (!ok || full !== 1'b1 || level !== 5'd16) begin
         failures++;
         $display("FAIL fill_full reached=%0b full=%0b level=%0d exp full=1 level=16",
                  ok, full, level);
      end
      checks++;
      if (n_uld - n0 != 16 || rx_empty_i !== 1'b0) begin
         failures++;
         $display("FAIL fill_no_17th_unload pulses=%0d rx_empty=%0b exp pulses=16 rx_empty=0",
                  n_uld - n0, rx_empty_i);
      end
      checks++;
      if (rd_data !== 8'h00) begin
         failures++; $display("FAIL fill_head got=%h exp=00", rd_data);
      end
      rd_ready = 1;
      step();
      rd_ready = 0;
      run_until(16, 100, ok);
      checks++;
      if (!ok || n_uld - n0 != 17 || level !== 5'd16) begin
         failures++;
         $display("FAIL fill_resume ok=%0b pulses=%0d level=%0d exp pulses=17 level=16",
                  ok, n_uld - n0, level);
      end
      for (int k = 1; k <= 16; k++) begin
         rd_ready = 1;
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(k)) begin
            failures++;
            $display("FAIL fill_order idx=%0d valid=%0b got=%h exp=%h", k, rd_valid, rd_data,
                     8'(k));
         end
         step();
      end
      rd_ready = 0;
      checks++;
      if (level !== 5'd0 || rd_valid !== 1'b0) begin
         failures++; $display("FAIL fill_drained level=%0d valid=%0b exp 0 0", level, rd_valid);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      int n0;
      rd_ready = 0;
      for (int i = 0; i < 3; i++) feed.push_back(8'($urandom));
      run_until(3, 200, ok);
      repeat (3) step();
      checks++;
      if (!ok || level !== 5'd3) begin
         failures++; $display("FAIL simul_setup ok=%0b level=%0d exp=3", ok, level);
      end
      load_now(8'($urandom));
      step();
      step();
      // Now in the capture cycle: pop and write land on the same edge.
      rd_ready = 1;
      step();
      rd_ready = 0;
      checks++;
      if (level !== 5'd3 || rd_data !== mq[0]) begin
         failures++;
         $display("FAIL simul_level level=%0d head=%h exp level=3 head=%h", level, rd_data,
                  mq[0]);
      end
      // Random traffic over 40 bytes: pointers wrap several times.
      n0 = n_uld;
      for (int i = 0; i < 40; i++) feed.push_back(8'($urandom));
      for (int c = 0; c < 450; c++) begin
         rd_ready = ($urandom_range(0, 9) < 4);
         step();
         checks++;
         if (level !== 5'(mq.size()) || rd_valid !== (mq.size() > 0) ||
             (mq.size() > 0 && rd_data !== mq[0])) begin
            failures++;
            $display("FAIL wrap_cycle c=%0d level=%0d valid=%0b data=%h exp level=%0d head=%h",
                     c, level, rd_valid, rd_data, mq.size(),
                     (mq.size() > 0) ? mq[0] : 8'h00);
         end
      end
      rd_ready = 1;
      repeat (60) step();
      rd_ready = 0;
      checks++;
      if (level !== 5'd0 || n_uld - n0 != 40 || uld_double) begin
         failures++;
         $display("FAIL wrap_end level=%0d pulses=%0d long_pulse=%0b exp 0 40 0",
                  level, n_uld - n0, uld_double);
      end
   endtask

   task automatic test_flush();
      bit ok;
      rd_ready = 0;
      for (int i = 0; i < 5; i++) feed.push_back(8'($urandom_range(0, 127)));
      run_until(5, 200, ok);
      repeat (3) step();
      checks++;
      if (!ok || level !== 5'd5) begin
         failures++; $display("FAIL flush_setup ok=%0b level=%0d exp=5", ok, level);
      end
      load_now(8'hEE);
      step();
      step();
      flush = 1;
      step();
      flush = 0;
      checks++;
      if (level !== 5'd0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_clear level=%0d valid=%0b exp level=0 valid=0", level, rd_valid);
      end
      feed.push_back(8'h11);
      feed.push_back(8'h22);
      run_until(2, 100, ok);
      checks++;
      if (!ok || rd_data !== 8'h11 || level !== 5'd2) begin
         failures++;
         $display("FAIL flush_after ok=%0b head=%h level=%0d exp head=11 level=2",
                  ok, rd_data, level);
      end
      rd_ready = 1;
      step();
      checks++;
      if (rd_data !== 8'h22) begin
         failures++; $display("FAIL flush_second got=%h exp=22", rd_data);
      end
      step();
      rd_ready = 0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n0;
      rd_ready = 0;
      feed.push_back(8'h01);
      feed.push_back(8'h02);
      run_until(2, 100, ok);
      repeat (3) step();
      load_now(8'h5A);
      n0 = n_uld;
      step();
      checks++;
      if (uld_rx_data_o !== 1'b1 || level !== 5'd2) begin
         failures++;
         $display("FAIL rstmid_setup uld=%0b level=%0d exp uld=1 level=2", uld_rx_data_o, level);
      end
      #2;
      reset = 1;
      #1;
      model_clear();
      checks++;
      if (uld_rx_data_o !== 1'b0 || level !== 5'd0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_async uld=%0b level=%0d valid=%0b exp 0 0 0",
                  uld_rx_data_o, level, rd_valid);
      end
      @(posedge rxclk);
      #1;
      reset = 0;
      run_until(1, 50, ok);
      checks++;
      if (!ok || rd_data !== 8'h5A || level !== 5'd1 || n_uld - n0 != 1) begin
         failures++;
         $display("FAIL rstmid_restart ok=%0b head=%h level=%0d pulses=%0d exp 5a 1 1",
                  ok, rd_data, level, n_uld - n0);
      end
      rd_ready = 1;
      step();
      rd_ready = 0;
   endtask

`ifdef UART_RX_FIFO_DROP_EN
   task automatic test_drop();
      int n0;
      rd_ready = 0;
      n0 = n_uld;
      for (int i = 0; i < 16; i++) feed.push_back(8'(i));
      for (int i = 0; i < 3; i++) feed.push_back(8'(8'h80 + i));
      for (int c = 0; c < 800; c++) begin
         if (feed.size() == 0 && !rx_hold && !prev_uld) break;
         step();
      end
      repeat (3) step();
      checks++;
      if (n_uld - n0 != 19 || drop_cnt !== 8'd3 || drop_m != 3 || level !== 5'd16) begin
         failures++;
         $display("FAIL drop_count pulses=%0d drop_cnt=%0d level=%0d exp 19 3 16",
                  n_uld - n0, drop_cnt, level);
      end
      for (int k = 0; k < 16; k++) begin
         rd_ready = 1;
         checks++;
         if (rd_data !== 8'(k)) begin
            failures++; $display("FAIL drop_contents idx=%0d got=%h exp=%h", k, rd_data, 8'(k));
         end
         step();
      end
      rd_ready = 0;
      flush = 1;
      step();
      flush = 0;
      checks++;
      if (drop_cnt !== 8'd0) begin
         failures++; $display("FAIL drop_flush got=%0d exp=0", drop_cnt);
      end
   endtask
`endif

   initial begin
      reset = 1; en = 0; flush = 0; rd_ready = 0;
      rx_empty_i = 1; rx_data_i = 8'h00;
      test_reset();
      test_single_byte();
`ifndef UART_RX_FIFO_DROP_EN
      test_fill();
`endif
      test_simultaneous();
      test_flush();
      test_reset_mid();
`ifdef UART_RX_FIFO_DROP_EN
      test_drop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
